// File: rtl/mac_sched_if.sv
// Request, configuration, MAC-atom drive and response signals of the MAC scheduler.
// The slave modport is the scheduler side; master is the requester/atom side.
interface mac_sched_if #(
  parameter int unsigned COUNT_WIDTH = 32,
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ID_WIDTH    = 2
);
  logic [NUM_REQ-1:0]             i__req_valid;
  logic [NUM_REQ-1:0]             o__req_ready;
  logic [NUM_REQ*COUNT_WIDTH-1:0] i__req_pkt;
  logic [NUM_REQ-1:0]             i__req_sel1;
  logic [NUM_REQ-1:0]             i__req_sel2;
  logic [COUNT_WIDTH-1:0]         i__cfg_constant;
  logic                           i__cfg_we;
  logic                           i__hold;
  logic [COUNT_WIDTH-1:0]         o__mac_constant;
  logic [COUNT_WIDTH-1:0]         o__mac_pkt_1;
  logic                           o__mac_sel1;
  logic                           o__mac_sel2;
  logic [COUNT_WIDTH-1:0]         i__mac_read;
  logic                           o__rsp_valid;
  logic [ID_WIDTH-1:0]            o__rsp_id;
  logic [COUNT_WIDTH-1:0]         o__rsp_data;

  modport slave (
    input  i__req_valid, i__req_pkt, i__req_sel1, i__req_sel2,
    input  i__cfg_constant, i__cfg_we, i__hold, i__mac_read,
    output o__req_ready, o__mac_constant, o__mac_pkt_1, o__mac_sel1, o__mac_sel2,
    output o__rsp_valid, o__rsp_id, o__rsp_data
  );

  modport master (
    output i__req_valid, i__req_pkt, i__req_sel1, i__req_sel2,
    output i__cfg_constant, i__cfg_we, i__hold, i__mac_read,
    input  o__req_ready, o__mac_constant, o__mac_pkt_1, o__mac_sel1, o__mac_sel2,
    input  o__rsp_valid, o__rsp_id, o__rsp_data
  );
endinterface

// File: rtl/mac_sched.sv
// Round-robin scheduler sharing one multiply-accumulate atom among NUM_REQ requesters.
// Ops are issued one per cycle; each response returns 3 cycles after its grant.
module mac_sched #(
  parameter int unsigned COUNT_WIDTH = 32,
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ID_WIDTH    = 2
) (
  input  logic       clk,
  input  logic       rst,
  mac_sched_if.slave bus
);

  localparam int unsigned PIPE_DEPTH = 3;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e                               state_q, state_d;
  logic [ID_WIDTH-1:0]                  rr_ptr_q, rr_ptr_d;
  logic [COUNT_WIDTH-1:0]               cfg_q, cfg_d;
  logic [COUNT_WIDTH-1:0]               mac_constant_q, mac_constant_d;
  logic [COUNT_WIDTH-1:0]               mac_pkt_1_q, mac_pkt_1_d;
  logic                                 mac_sel1_q, mac_sel1_d;
  logic                                 mac_sel2_q, mac_sel2_d;
  logic [PIPE_DEPTH-1:0]                pipe_vld_q, pipe_vld_d;
  logic [PIPE_DEPTH-1:0][ID_WIDTH-1:0]  pipe_id_q, pipe_id_d;

  logic [NUM_REQ-1:0]                   ready_c;
  logic [ID_WIDTH-1:0]                  grant_id_c;
  logic [ID_WIDTH-1:0]                  scan_idx_c;
  logic                                 xfer_c;

  // Round-robin pick: first valid requester at or above rr_ptr, with wrap
  always_comb begin
    ready_c    = '0;
    grant_id_c = '0;
    scan_idx_c = '0;
    xfer_c     = 1'b0;
    if (state_q == ST_RUN && !bus.i__hold) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        scan_idx_c = ID_WIDTH'((32'(rr_ptr_q) + 32'(i)) % 32'(NUM_REQ));
        if (!xfer_c && bus.i__req_valid[scan_idx_c]) begin
          ready_c[scan_idx_c] = 1'b1;
          grant_id_c          = scan_idx_c;
          xfer_c              = 1'b1;
        end
      end
    end
  end

  // Next-state: FSM, pointer, cfg, atom drive and response pipeline
  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    cfg_d          = cfg_q;
    mac_sel1_d     = 1'b0;
    mac_sel2_d     = 1'b1;
    mac_pkt_1_d    = COUNT_WIDTH'(1);
    mac_constant_d = cfg_q;
    pipe_vld_d     = '0;
    pipe_id_d      = '0;

    for (int unsigned i = 1; i < PIPE_DEPTH; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_id_d[i]  = pipe_id_q[i-1];
    end

    if (bus.i__cfg_we) begin
      cfg_d = bus.i__cfg_constant;
    end

    case (state_q)
      ST_INIT: begin
        state_d     = ST_RUN;
        mac_sel1_d  = 1'b1;
        mac_sel2_d  = 1'b0;
        mac_pkt_1_d = '0;
      end
      ST_RUN: begin
        if (xfer_c) begin
          rr_ptr_d = (grant_id_c == ID_WIDTH'(NUM_REQ - 1)) ? '0
                                                            : grant_id_c + ID_WIDTH'(1);
          for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (ready_c[k]) begin
              mac_pkt_1_d = bus.i__req_pkt[k*COUNT_WIDTH +: COUNT_WIDTH];
              mac_sel1_d  = bus.i__req_sel1[k];
              mac_sel2_d  = bus.i__req_sel2[k];
            end
          end
          pipe_vld_d[0] = 1'b1;
          pipe_id_d[0]  = grant_id_c;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Reset value of the atom drive is the clear op
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_INIT;
      rr_ptr_q       <= '0;
      cfg_q          <= '0;
      mac_constant_q <= '0;
      mac_pkt_1_q    <= '0;
      mac_sel1_q     <= 1'b1;
      mac_sel2_q     <= 1'b0;
      pipe_vld_q     <= '0;
      pipe_id_q      <= '0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      cfg_q          <= cfg_d;
      mac_constant_q <= mac_constant_d;
      mac_pkt_1_q    <= mac_pkt_1_d;
      mac_sel1_q     <= mac_sel1_d;
      mac_sel2_q     <= mac_sel2_d;
      pipe_vld_q     <= pipe_vld_d;
      pipe_id_q      <= pipe_id_d;
    end
  end

  assign bus.o__req_ready    = ready_c;
  assign bus.o__mac_constant = mac_constant_q;
  assign bus.o__mac_pkt_1    = mac_pkt_1_q;
  assign bus.o__mac_sel1     = mac_sel1_q;
  assign bus.o__mac_sel2     = mac_sel2_q;
  assign bus.o__rsp_valid    = pipe_vld_q[PIPE_DEPTH-1];
  assign bus.o__rsp_id       = pipe_id_q[PIPE_DEPTH-1];
  // Atom state already reflects the op whose response is leaving the pipe
  assign bus.o__rsp_data     = bus.i__mac_read;

endmodule

// File: tb/tb_mac_sched.sv
// Bench for mac_sched: external MAC atom model plus a transaction-level scoreboard
// predicting grants, atom drive and responses from the scheduling rules.
module tb_mac_sched;
  localparam int unsigned CW = 32;
  localparam int unsigned NR = 4;
  localparam int unsigned IW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mac_sched_if #(.COUNT_WIDTH(CW), .NUM_REQ(NR), .ID_WIDTH(IW)) bus ();

  mac_sched #(.COUNT_WIDTH(CW), .NUM_REQ(NR), .ID_WIDTH(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // External MAC atom: inputs registered once, then state updated
  logic [CW-1:0] atom_state = 32'hDEAD_BEEF;
  logic          a_sel1 = 1'b0;
  logic          a_sel2 = 1'b1;
  logic [CW-1:0] a_pkt  = 32'd1;
  logic [CW-1:0] a_const = 32'd0;
  always @(posedge clk) begin
    a_sel1     <= bus.o__mac_sel1;
    a_sel2     <= bus.o__mac_sel2;
    a_pkt      <= bus.o__mac_pkt_1;
    a_const    <= bus.o__mac_constant;
    atom_state <= (a_sel1 ? '0 : atom_state) * (a_sel2 ? a_pkt : a_const);
  end
  assign bus.i__mac_read = atom_state;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard state
  typedef struct {
    int            due;
    int            id;
    logic [CW-1:0] data;
  } rsp_t;

  rsp_t          rsp_q[$];
  int            cyc = 0;
  logic          m_init = 1'b1;
  int            m_rr = 0;
  logic [CW-1:0] m_cfg = '0;
  logic [CW-1:0] m_acc = '0;
  logic          e_sel1 = 1'b1;
  logic          e_sel2 = 1'b0;
  logic [CW-1:0] e_pkt = '0;
  logic [CW-1:0] e_const = '0;
  logic          e_const_chk = 1'b1;

  task automatic eval_cycle();
    int            g;
    int            k;
    logic [NR-1:0] exp_rdy;
    logic          exp_v;
    logic          s1, s2;
    logic [CW-1:0] p;
    rsp_t          r;
    if (rst) begin
      rsp_q.delete();
      m_rr = 0; m_cfg = '0; m_acc = '0; m_init = 1'b1;
      check("rst_ready", 64'(bus.o__req_ready), 64'd0);
      check("rst_rsp_valid", 64'(bus.o__rsp_valid), 64'd0);
      check("rst_rsp_id", 64'(bus.o__rsp_id), 64'd0);
      check("rst_sel1", 64'(bus.o__mac_sel1), 64'd1);
      check("rst_sel2", 64'(bus.o__mac_sel2), 64'd0);
      check("rst_pkt", 64'(bus.o__mac_pkt_1), 64'd0);
      check("rst_const", 64'(bus.o__mac_constant), 64'd0);
      e_sel1 = 1'b1; e_sel2 = 1'b0; e_pkt = '0; e_const = '0; e_const_chk = 1'b1;
      return;
    end
    check("drive_sel1", 64'(bus.o__mac_sel1), 64'(e_sel1));
    check("drive_sel2", 64'(bus.o__mac_sel2), 64'(e_sel2));
    check("drive_pkt", 64'(bus.o__mac_pkt_1), 64'(e_pkt));
    if (e_const_chk) check("drive_const", 64'(bus.o__mac_constant), 64'(e_const));

    exp_v = (rsp_q.size() > 0) && (rsp_q[0].due == cyc);
    check("rsp_valid", 64'(bus.o__rsp_valid), 64'(exp_v));
    if (exp_v) begin
      r = rsp_q.pop_front();
      check("rsp_id", 64'(bus.o__rsp_id), 64'(r.id));
      check("rsp_data", 64'(bus.o__rsp_data), 64'(r.data));
    end

    g = -1;
    if (!m_init && !bus.i__hold) begin
      for (int i = 0; i < int'(NR); i++) begin
        k = (m_rr + i) % int'(NR);
        if (g < 0 && bus.i__req_valid[k]) g = k;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("req_ready", 64'(bus.o__req_ready), 64'(exp_rdy));

    if (m_init) begin
      e_sel1 = 1'b1; e_sel2 = 1'b0; e_pkt = '0; e_const = m_cfg; e_const_chk = 1'b1;
      m_init = 1'b0;
    end else if (g >= 0) begin
      s1 = bus.i__req_sel1[g];
      s2 = bus.i__req_sel2[g];
      p  = bus.i__req_pkt[g*CW +: CW];
      m_acc = (s1 ? '0 : m_acc) * (s2 ? p : m_cfg);
      rsp_q.push_back('{due: cyc + 3, id: g, data: m_acc});
      e_sel1 = s1; e_sel2 = s2; e_pkt = p; e_const = m_cfg; e_const_chk = 1'b1;
      m_rr = (g + 1) % int'(NR);
    end else begin
      e_sel1 = 1'b0; e_sel2 = 1'b1; e_pkt = 32'd1; e_const_chk = 1'b0;
    end
    if (bus.i__cfg_we) m_cfg = bus.i__cfg_constant;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      eval_cycle();
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic set_idle();
    bus.i__req_valid    = '0;
    bus.i__req_sel1     = '0;
    bus.i__req_sel2     = '0;
    bus.i__req_pkt      = '0;
    bus.i__cfg_we       = 1'b0;
    bus.i__cfg_constant = '0;
    bus.i__hold         = 1'b0;
  endtask

  task automatic set_req(input int k, input logic s1, input logic s2, input logic [CW-1:0] p);
    bus.i__req_valid[k]        = 1'b1;
    bus.i__req_sel1[k]         = s1;
    bus.i__req_sel2[k]         = s2;
    bus.i__req_pkt[k*CW +: CW] = p;
  endtask

  task automatic write_cfg(input logic [CW-1:0] v);
    bus.i__cfg_we = 1'b1; bus.i__cfg_constant = v;
    tick(1);
    bus.i__cfg_we = 1'b0;
  endtask

  initial begin
    set_idle();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;

    // Idle after reset: identity drive, no responses, atom cleared
    tick(8);
    check("idle_atom_zero", 64'(atom_state), 64'd0);

    // Single-requester op sequence with constant 3
    write_cfg(32'd3);
    set_req(0, 1'b1, 1'b1, 32'd5);
    tick(1);
    set_req(0, 1'b0, 1'b0, 32'd5);
    tick(1);
    set_req(0, 1'b0, 1'b1, 32'd5);
    tick(1);
    set_idle();
    tick(5);

    // All requesters valid: rotating grants, one per cycle
    for (int k = 0; k < int'(NR); k++) set_req(k, 1'($urandom), 1'($urandom), $urandom);
    tick(12);
    set_idle();
    tick(4);

    // cfg write in the same cycle as a transfer
    write_cfg(32'd2);
    set_req(1, 1'b0, 1'b0, 32'd9);
    bus.i__cfg_we = 1'b1; bus.i__cfg_constant = 32'd7;
    tick(1);
    check("cfg_old_used", 64'(bus.o__mac_constant), 64'd2);
    bus.i__cfg_we = 1'b0;
    tick(1);
    check("cfg_new_used", 64'(bus.o__mac_constant), 64'd7);
    set_idle();
    tick(4);

    // Hold with two ops in flight
    set_req(2, 1'b0, 1'b1, 32'd4);
    set_req(3, 1'b0, 1'b0, 32'd6);
    tick(2);
    bus.i__hold = 1'b1;
    tick(6);
    set_idle();
    tick(3);

    // Reset pulsed one cycle after a transfer
    set_req(2, 1'b0, 1'b1, 32'd11);
    tick(1);
    set_idle();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(6);
    check("post_rst_atom_zero", 64'(atom_state), 64'd0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      bus.i__req_valid    = NR'($urandom);
      bus.i__req_sel1     = NR'($urandom);
      bus.i__req_sel2     = NR'($urandom);
      bus.i__req_pkt      = {$urandom, $urandom, $urandom, $urandom};
      bus.i__hold         = ($urandom_range(0, 7) == 0);
      bus.i__cfg_we       = ($urandom_range(0, 7) == 0);
      bus.i__cfg_constant = $urandom;
      rst                 = ($urandom_range(0, 99) == 0);
      tick(1);
    end
    rst = 1'b0;
    set_idle();
    tick(6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
